// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Compare/test ops always set flags and never write a result back.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// accumulating into a WIDTH-bit partial seeded with acc (MLA) or zero (MUL).
module alu_seq_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             acc_en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (start_i) begin
      mcand_d   = a_i;
      mplier_d  = b_i;
      partial_d = acc_en_i ? acc_i : '0;
      cnt_d     = CNT_W'(WIDTH);
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        partial_d = partial_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  // High during the cycle whose edge performs the final iteration.
  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign product_o = partial_q;

endmodule

// File: rtl/alu_seq_flags.sv
// Sequential ARM data-processing ALU with NZCV flag register, iterative MUL/MLA
// and valid/ready handshakes on both the request and result sides.
module alu_seq_flags
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             set_s,
  input  logic             mul_en,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             shift_c,
  input  logic             flag_wr,
  input  logic [3:0]       flag_din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [3:0]       flags
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wr_en_q, wr_en_d;
  logic [3:0]       flags_q, flags_d;
  logic             set_s_q, set_s_d;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] x, y, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, is_arith, alu_c, alu_v;
  logic [3:0]       alu_flags;

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !reset;
  assign accept   = in_valid && in_ready;

  // Subtracts are computed as x + ~y + cin so the carry-out is the no-borrow bit.
  always_comb begin
    x        = a;
    y        = b;
    cin      = 1'b0;
    is_arith = 1'b1;
    alu_res  = '0;
    sum      = '0;
    alu_c    = shift_c;
    alu_v    = flags_q[FLAG_V];
    case (op)
      OP_AND, OP_TST: begin is_arith = 1'b0; alu_res = a & b;  end
      OP_EOR, OP_TEQ: begin is_arith = 1'b0; alu_res = a ^ b;  end
      OP_ORR:         begin is_arith = 1'b0; alu_res = a | b;  end
      OP_MOV:         begin is_arith = 1'b0; alu_res = b;      end
      OP_BIC:         begin is_arith = 1'b0; alu_res = a & ~b; end
      OP_MVN:         begin is_arith = 1'b0; alu_res = ~b;     end
      OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
      OP_ADC:         cin = flags_q[FLAG_C];
      OP_SBC:         begin y = ~b; cin = flags_q[FLAG_C]; end
      OP_RSC:         begin x = b; y = ~a; cin = flags_q[FLAG_C]; end
      default:        ;
    endcase
    if (is_arith) begin
      sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      alu_res = sum[WIDTH-1:0];
      alu_c   = sum[WIDTH];
      alu_v   = (x[WIDTH-1] == y[WIDTH-1]) && (alu_res[WIDTH-1] != x[WIDTH-1]);
    end
    alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    wr_en_d     = wr_en_q;
    flags_d     = flags_q;
    set_s_d     = set_s_q;
    mul_start   = 1'b0;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (mul_en) begin
            mul_start = 1'b1;
            set_s_d   = set_s;
            state_d   = StMul;
          end else begin
            result_d    = alu_res;
            wr_en_d     = !is_test_op(op);
            out_valid_d = 1'b1;
            if (set_s || is_test_op(op)) begin
              flags_d = alu_flags;
            end
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        result_d    = mul_product;
        wr_en_d     = 1'b1;
        out_valid_d = 1'b1;
        if (set_s_q) begin
          flags_d[FLAG_N] = mul_product[WIDTH-1];
          flags_d[FLAG_Z] = (mul_product == '0);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A direct flag load overrides any ALU/MUL flag update on the same edge.
    if (flag_wr) begin
      flags_d = flag_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      wr_en_q     <= 1'b0;
      flags_q     <= '0;
      set_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wr_en_q     <= wr_en_d;
      flags_q     <= flags_d;
      set_s_q     <= set_s_d;
    end
  end

  alu_seq_mul #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (mul_start),
    .acc_en_i (acc_en),
    .a_i      (a),
    .b_i      (b),
    .acc_i    (acc),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign wr_en     = wr_en_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_flags.sv
// Directed plus randomized bench for alu_seq_flags against an arithmetic reference model.
module tb_alu_seq_flags;

  localparam int unsigned W = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic          set_s;
  logic          mul_en;
  logic          acc_en;
  logic [W-1:0]  a, b, acc;
  logic          shift_c;
  logic          flag_wr;
  logic [3:0]    flag_din;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          wr_en;
  logic [3:0]    flags;

  int            vectors = 0;
  int            miscompares = 0;
  logic [3:0]    m_flags = 4'b0000;

  alu_seq_flags #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .set_s    (set_s),
    .mul_en   (mul_en),
    .acc_en   (acc_en),
    .a        (a),
    .b        (b),
    .acc      (acc),
    .shift_c  (shift_c),
    .flag_wr  (flag_wr),
    .flag_din (flag_din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .wr_en    (wr_en),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_ref(input logic [31:0] p, q, input logic ci,
                         output logic [31:0] r, output logic co, vo);
    longint unsigned u;
    longint          sg;
    u  = 64'(p) + 64'(q) + 64'(ci);
    sg = longint'($signed(p)) + longint'($signed(q)) + longint'(ci);
    r  = u[31:0];
    co = (u > 64'hFFFF_FFFF);
    vo = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
  endtask

  task automatic sub_ref(input logic [31:0] p, q, input logic bi,
                         output logic [31:0] r, output logic co, vo);
    longint sg;
    r  = p - q - 32'(bi);
    co = (64'(p) >= 64'(q) + 64'(bi));
    sg = longint'($signed(p)) - longint'($signed(q)) - longint'(bi);
    vo = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
  endtask

  // Reference: computes the result and updates m_flags as the op would.
  task automatic model(input logic [3:0] o, input logic s, me, ae,
                       input logic [31:0] x, y, z, input logic sc,
                       output logic [31:0] r, output logic w);
    logic        cf, vf, c_in, test;
    logic [63:0] prod;
    c_in = m_flags[1];
    cf   = sc;
    vf   = m_flags[0];
    test = (o >= 4'h8) && (o <= 4'hB);
    w    = 1'b1;
    r    = '0;
    if (me) begin
      prod = 64'(x) * 64'(y) + (ae ? 64'(z) : 64'd0);
      r    = prod[31:0];
      if (s) begin
        m_flags[3] = r[31];
        m_flags[2] = (r == 32'd0);
      end
    end else begin
      case (o)
        4'h0, 4'h8: r = x & y;
        4'h1, 4'h9: r = x ^ y;
        4'hC:       r = x | y;
        4'hD:       r = y;
        4'hE:       r = x & ~y;
        4'hF:       r = ~y;
        4'h4, 4'hB: add_ref(x, y, 1'b0, r, cf, vf);
        4'h5:       add_ref(x, y, c_in, r, cf, vf);
        4'h2, 4'hA: sub_ref(x, y, 1'b0, r, cf, vf);
        4'h6:       sub_ref(x, y, !c_in, r, cf, vf);
        4'h3:       sub_ref(y, x, 1'b0, r, cf, vf);
        4'h7:       sub_ref(y, x, !c_in, r, cf, vf);
        default:    ;
      endcase
      w = !test;
      if (s || test) m_flags = {r[31], (r == 32'd0), cf, vf};
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic s, me, ae,
                       input logic [31:0] x, y, z, input logic sc,
                       input logic fw, input logic [3:0] fd);
    logic [31:0] er;
    logic        ew;
    int          t, busy;
    op = o; set_s = s; mul_en = me; acc_en = ae;
    a = x; b = y; acc = z; shift_c = sc;
    flag_wr = fw; flag_din = fd; in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 100) begin cycle(); t++; end
    chk("accept", 64'(in_ready), 64'd1);
    model(o, s, me, ae, x, y, z, sc, er, ew);
    if (fw) m_flags = fd;
    cycle();
    in_valid = 1'b0; flag_wr = 1'b0;
    a = $urandom; b = $urandom; acc = $urandom; shift_c = ~sc;
    t = 0; busy = 0;
    while (!out_valid && t < 100) begin
      if (!in_ready) busy++;
      cycle();
      t++;
    end
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("busy_cycles", 64'(busy), me ? 64'(W + 1) : 64'd0);
    if (ew) chk("result", 64'(result), 64'(er));
    chk("wr_en", 64'(wr_en), 64'(ew));
    chk("flags", 64'(flags), 64'(m_flags));
  endtask

  task automatic set_flags(input logic [3:0] d);
    flag_wr = 1'b1; flag_din = d;
    cycle();
    flag_wr = 1'b0;
    m_flags = d;
    chk("flag_wr", 64'(flags), 64'(d));
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic me, fw;
    int   hits;
    reset = 1'b1; in_valid = 1'b0; op = 4'h0; set_s = 1'b0; mul_en = 1'b0;
    acc_en = 1'b0; a = '0; b = '0; acc = '0; shift_c = 1'b0;
    flag_wr = 1'b0; flag_din = 4'h0; out_ready = 1'b1;

    repeat (3) cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // ADDS signed overflow
    do_op(4'h4, 1, 0, 0, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0);
    chk("adds_res", 64'(result), 64'h8000_0000);
    chk("adds_flags", 64'(flags), 64'b1001);

    // SUBS equal, then CMP negative
    do_op(4'h2, 1, 0, 0, 32'd5, 32'd5, 0, 0, 0, 0);
    chk("subs_flags", 64'(flags), 64'b0110);
    do_op(4'hA, 0, 0, 0, 32'd3, 32'd5, 0, 0, 0, 0);
    chk("cmp_wr_en", 64'(wr_en), 64'd0);
    chk("cmp_flags", 64'(flags), 64'b1000);

    // Carry chain: ADDS sets C, ADC consumes it, SBC with C clear
    do_op(4'h4, 1, 0, 0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0);
    chk("adds_c_flags", 64'(flags), 64'b0110);
    do_op(4'h5, 0, 0, 0, 32'd2, 32'd3, 0, 0, 0, 0);
    chk("adc_res", 64'(result), 64'd6);
    set_flags(4'b0000);
    do_op(4'h6, 0, 0, 0, 32'd10, 32'd4, 0, 0, 0, 0);
    chk("sbc_res", 64'(result), 64'd5);

    // MLA S preserves C and V
    set_flags(4'b0011);
    do_op(4'h0, 1, 1, 1, 32'd7, 32'd6, 32'd100, 0, 0, 0);
    chk("mla_res", 64'(result), 64'd142);
    chk("mla_flags", 64'(flags), 64'b0011);

    // ANDS: C from shifter, V kept; then again with a simultaneous flag load
    do_op(4'h0, 1, 0, 0, 32'hF0, 32'h0F, 0, 1, 0, 0);
    chk("ands_res", 64'(result), 64'd0);
    chk("ands_flags", 64'(flags), 64'b0111);
    do_op(4'h0, 1, 0, 0, 32'hF0, 32'h0F, 0, 1, 1, 4'b1000);
    chk("ands_flagwr", 64'(flags), 64'b1000);

    // Backpressure: result held, nothing accepted until out_ready returns
    cycle();
    out_ready = 1'b0;
    do_op(4'h4, 0, 0, 0, 32'd10, 32'd20, 0, 0, 0, 0);
    op = 4'h2; set_s = 1'b1; mul_en = 1'b0; a = 32'd100; b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_result", 64'(result), 64'd30);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_flags", 64'(flags), 64'(m_flags));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    do_op(4'h2, 1, 0, 0, 32'd100, 32'd1, 0, 0, 0, 0);
    chk("after_bp_res", 64'(result), 64'd99);

    // Reset in the middle of a multiply
    op = 4'h0; set_s = 1'b1; mul_en = 1'b1; acc_en = 1'b0;
    a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    #1;
    chk("mul_accept", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    chk("abort_in_ready_rst", 64'(in_ready), 64'd0);
    reset = 1'b0;
    m_flags = 4'b0000;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    hits = 0;
    repeat (40) begin
      cycle();
      if (out_valid) hits++;
    end
    chk("abort_no_result", 64'(hits), 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        set_flags(4'($urandom));
      end else begin
        me = ($urandom_range(0, 7) == 0);
        fw = !me && ($urandom_range(0, 9) == 0);
        do_op(4'($urandom), 1'($urandom), me, 1'($urandom), rnd_val(), rnd_val(), rnd_val(),
              1'($urandom), fw, 4'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq_flags.md
Name: alu_seq_flags

Overview:
- Parametrised, sequential successor to the datapath ALU.
- Executes the full 16-entry ARM data-processing opcode set at WIDTH bits.
- Owns the NZCV flag register and implements ARM-correct carry/overflow, including carry = NOT borrow on subtracts.
- Adds an iterative shift-add MUL/MLA unit and a valid/ready handshake on both sides. Sits between decode/operand-fetch and register writeback.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; transfer when in_valid&in_ready.
- op  input  4  ARM data-processing opcode (0 AND … F MVN).
- set_s  input  1  S bit; update flags.
- mul_en  input  1  perform multiply instead of op.
- acc_en  input  1  with mul_en: MLA (add acc).
- a, b, acc  input  WIDTH  operands (Rn, shifter operand, Rd accumulate).
- shift_c  input  1  shifter carry-out, used as C for logical ops.
- flag_wr  input  1  direct flag load (MSR).
- flag_din  input  4  {N,Z,C,V} for flag_wr.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- wr_en  output  1  result is to be written back (0 for TST/TEQ/CMP/CMN).
- flags  output  4  registered {N,Z,C,V}.

Behaviour:
- Reset (sync): out_valid=0, result=0, wr_en=0, flags=0, FSM=IDLE. in_ready=0 while reset is high.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !reset.
- FSM states:
  - IDLE: accept. Non-mul op → result/flags registered at the accepting edge, out_valid=1 next cycle (latency 1). mul_en → MUL.
  - MUL: WIDTH iterations, one bit of b per cycle, LSB first, accumulating into a WIDTH-bit partial (initial = acc if acc_en else 0). Then →DONE.
  - DONE: load result, out_valid=1, →IDLE. MUL latency = WIDTH+1 cycles.
- Output hold: while out_valid & !out_ready, result/wr_en/flags stay stable and no new op is accepted.
- Output clear: out_valid clears on out_ready unless a new result is loaded at the same edge.
- Arithmetic (C = flags.C at acceptance, modulo 2^WIDTH):
  - ADD/CMN: a+b.
  - ADC: a+b+C.
  - SUB/CMP: a-b.
  - SBC: a-b-!C.
  - RSB: b-a.
  - RSC: b-a-!C.
- Logic:
  - AND/TST: a&b.
  - EOR/TEQ: a^b.
  - ORR: a|b.
  - MOV: b.
  - BIC: a&~b.
  - MVN: ~b.
- Flags:
  - N = msb(result).
  - Z = (result==0).
  - Adds: C = carry-out; V = (a.msb==b.msb)&(r.msb!=a.msb).
  - Subtracts: C = no-borrow; V = (x.msb!=y.msb)&(r.msb!=x.msb) for x-y.
  - Logical ops: C = shift_c, V unchanged.
  - Multiply: N, Z updated; C, V unchanged.
- Flag update condition: flags are written only if set_s, or unconditionally for TST/TEQ/CMP/CMN. wr_en=0 for those four.
- Flag update timing: the update lands with the result load, so the next accepted op sees the new C (no hazard).
- flag_wr: loads flag_din at the edge. If it coincides with an ALU flag update, flag_wr wins.
- Reset during MUL: aborts; no out_valid; state as at reset.
- in_valid ignored while in_ready=0; operands are captured at acceptance (inputs may change afterwards).

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_AND..OP_MVN.
  - FSM state encoding IDLE/MUL/DONE.
  - flag bit indices N=3, Z=2, C=1, V=0.
  - helper function is_test_op(op).
- Sub-module alu_seq_mul: iterative shift-add multiplier with start/done, parametrised WIDTH. Top instantiates it and muxes results.

Test Plan:
1. ADDS a=0x7FFFFFFF, b=1 → one cycle later out_valid=1, result=0x80000000, flags N1 Z0 C0 V1, wr_en=1.
2. SUBS 5-5 → result 0, Z1 C1 V0. Then CMP a=3, b=5 → wr_en=0, flags N1 Z0 C0 V0, result not written back.
3. ADDS 0xFFFFFFFF+1 (C=1), then ADC 2+3 → result 6. Then SBC 10-4 with C=0 → result 5.
4. MLA S a=7, b=6, acc=100, prior C=1, V=1 → in_ready=0 for WIDTH+1 cycles; result 142, N0 Z0, C1 V1 preserved.
5. ANDS 0xF0 & 0x0F with shift_c=1 → result 0, Z1 C1, V unchanged. Same cycle flag_wr, flag_din=0b1000 → flags=1000.
6. Backpressure and reset:
   - out_ready held low 3 cycles after ADD → result stable, in_ready=0; next op accepted the cycle out_ready rises.
   - reset asserted at MUL iteration 10 → next cycle out_valid=0, flags=0, in_ready=1.
